// File: rtl/sha256_core.sv
// SHA-256 compression core: one 512-bit block per command, one round per clock.
//
// Ports:
//   clk_i          - clock, all state updates on the rising edge
//   rst_i          - synchronous active-high reset
//   init_i         - start a new hash from the IV using block_i
//   next_i         - chain from the current digest using block_i
//   block_i        - 512-bit message block, W0 = block_i[511:480]
//   ready_o        - idle and able to accept init_i / next_i
//   digest_o       - chaining value H0..H7, H0 = digest_o[255:224]
//   digest_valid_o - digest_o holds the result of the last accepted block
module sha256_core (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         init_i,
    input  logic         next_i,
    input  logic [511:0] block_i,
    output logic         ready_o,
    output logic [255:0] digest_o,
    output logic         digest_valid_o
);

    typedef enum logic [1:0] {StIdle, StRound, StFinal} state_e;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    state_e      state_q;
    logic [5:0]  t_q;
    logic [31:0] v_q [8];   // working variables a..h
    logic [31:0] h_q [8];   // chaining value H0..H7
    logic [31:0] w_q [16];  // schedule window, w_q[0] is W[t]
    logic        ready_q;
    logic        valid_q;

    logic [31:0] big_s0, big_s1, ch, maj, t1, t2, w_new;

    always_comb begin
        big_s1 = rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25);
        ch     = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
        t1     = v_q[7] + big_s1 + ch + K[t_q] + w_q[0];
        big_s0 = rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22);
        maj    = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
        t2     = big_s0 + maj;
        // W[t+16] from the window W[t..t+15]
        w_new  = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
               + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            t_q     <= 6'd0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                v_q[i] <= 32'h0;
                h_q[i] <= 32'h0;
            end
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (init_i || next_i) begin
                        for (int i = 0; i < 16; i++) w_q[i] <= block_i[511 - 32*i -: 32];
                        for (int i = 0; i < 8; i++) begin
                            if (init_i) begin
                                v_q[i] <= IV[i];
                                h_q[i] <= IV[i];
                            end else begin
                                v_q[i] <= h_q[i];
                            end
                        end
                        t_q     <= 6'd0;
                        ready_q <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= StRound;
                    end
                end
                StRound: begin
                    v_q[0] <= t1 + t2;
                    v_q[1] <= v_q[0];
                    v_q[2] <= v_q[1];
                    v_q[3] <= v_q[2];
                    v_q[4] <= v_q[3] + t1;
                    v_q[5] <= v_q[4];
                    v_q[6] <= v_q[5];
                    v_q[7] <= v_q[6];
                    for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
                    w_q[15] <= w_new;
                    t_q     <= t_q + 6'd1;
                    if (t_q == 6'd63) state_q <= StFinal;
                end
                StFinal: begin
                    for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
                    ready_q <= 1'b1;
                    valid_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ready_o        = ready_q;
    assign digest_valid_o = valid_q;
    assign digest_o       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

endmodule

// File: tb/tb_sha256_core.sv
// Self-checking bench for sha256_core: known-answer vectors plus random blocks
// compared against a whole-message behavioural SHA-256 compression model.
module tb_sha256_core;

    logic         clk;
    logic         rst_i;
    logic         init_i;
    logic         next_i;
    logic [511:0] block_i;
    logic         ready_o;
    logic [255:0] digest_o;
    logic         digest_valid_o;

    int checks = 0;
    int errors = 0;

    sha256_core dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .init_i         (init_i),
        .next_i         (next_i),
        .block_i        (block_i),
        .ready_o        (ready_o),
        .digest_o       (digest_o),
        .digest_valid_o (digest_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] IV_VEC =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_BLK1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {480'h0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Full-message form: expand all 64 schedule words first, then run rounds.
    function automatic logic [255:0] ref_compress(input logic [255:0] hin,
                                                  input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] r [8];
        logic [31:0] hv [8];
        logic [31:0] x1, x2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255 - 32*i -: 32];
            r[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            x1 = r[7] + (rr(r[4], 6) ^ rr(r[4], 11) ^ rr(r[4], 25))
               + ((r[4] & r[5]) ^ (~r[4] & r[6])) + KT[t] + w[t];
            x2 = (rr(r[0], 2) ^ rr(r[0], 13) ^ rr(r[0], 22))
               + ((r[0] & r[1]) ^ (r[0] & r[2]) ^ (r[1] & r[2]));
            r[7] = r[6]; r[6] = r[5]; r[5] = r[4]; r[4] = r[3] + x1;
            r[3] = r[2]; r[2] = r[1]; r[1] = r[0]; r[0] = x1 + x2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[i] + r[i];
        return res;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Present a command for one edge; returns #1 after the accept edge.
    task automatic issue(input logic ini, input logic nxt, input logic [511:0] blk);
        init_i  = ini;
        next_i  = nxt;
        block_i = blk;
        @(posedge clk); #1;
        init_i = 1'b0;
        next_i = 1'b0;
    endtask

    // Edges after accept until digest_valid_o is seen; -1 if the bound expires.
    task automatic wait_done(output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int k = 1; k <= 100; k++) begin
            if (!found) begin
                @(posedge clk); #1;
                if (digest_valid_o) begin
                    found = 1'b1;
                    n = k;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1; init_i = 1'b1; next_i = 1'b0; block_i = ABC_BLK;
        repeat (2) @(posedge clk);
        #1;
        init_i = 1'b0;
        rst_i  = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || digest_valid_o !== 1'b0 || digest_o !== 256'h0) begin
            errors++;
            $display("FAIL reset: got ready=%b valid=%b digest=%h, want 1 0 0",
                     ready_o, digest_valid_o, digest_o);
        end
    endtask

    task automatic test_abc();
        int n;
        issue(1'b1, 1'b0, ABC_BLK);
        checks++;
        if (ready_o !== 1'b0 || digest_valid_o !== 1'b0 || digest_o !== IV_VEC) begin
            errors++;
            $display("FAIL abc_accept: got ready=%b valid=%b digest=%h, want 0 0 %h",
                     ready_o, digest_valid_o, digest_o, IV_VEC);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (digest_o !== IV_VEC || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL abc_midround: got digest=%h ready=%b, want %h 0",
                     digest_o, ready_o, IV_VEC);
        end
        wait_done(n);
        checks++;
        if (n !== 55) begin
            errors++;
            $display("FAIL abc_latency: got %0d remaining edges, want 55", n);
        end
        checks++;
        if (digest_o !== ABC_DIG || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL abc_digest: got %h ready=%b, want %h 1", digest_o, ready_o, ABC_DIG);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (digest_valid_o !== 1'b1 || digest_o !== ABC_DIG) begin
            errors++;
            $display("FAIL abc_hold: got valid=%b digest=%h, want 1 %h",
                     digest_valid_o, digest_o, ABC_DIG);
        end
    endtask

    task automatic test_empty();
        int n;
        issue(1'b1, 1'b0, EMPTY_BLK);
        wait_done(n);
        checks++;
        if (n !== 65 || digest_o !== EMPTY_DIG) begin
            errors++;
            $display("FAIL empty: got lat=%0d digest=%h, want 65 %h", n, digest_o, EMPTY_DIG);
        end
    endtask

    task automatic test_two_block();
        int n;
        issue(1'b1, 1'b0, TWO_BLK1);
        wait_done(n);
        checks++;
        if (digest_o !== ref_compress(IV_VEC, TWO_BLK1)) begin
            errors++;
            $display("FAIL two_block_1: got %h, want %h", digest_o,
                     ref_compress(IV_VEC, TWO_BLK1));
        end
        issue(1'b0, 1'b1, TWO_BLK2);
        wait_done(n);
        checks++;
        if (n !== 65 || digest_o !== TWO_DIG) begin
            errors++;
            $display("FAIL two_block_2: got lat=%0d digest=%h, want 65 %h", n, digest_o, TWO_DIG);
        end
    endtask

    task automatic test_both_high();
        int n;
        issue(1'b0, 1'b1, EMPTY_BLK);  // disturb H so a wrongly chained next would differ
        wait_done(n);
        issue(1'b1, 1'b1, ABC_BLK);
        wait_done(n);
        checks++;
        if (digest_o !== ABC_DIG) begin
            errors++;
            $display("FAIL both_high: got %h, want %h", digest_o, ABC_DIG);
        end
    endtask

    task automatic test_ignore_during_round();
        int n;
        issue(1'b1, 1'b0, ABC_BLK);
        for (int k = 0; k < 40; k++) begin
            block_i = rand_block();
            init_i  = (k == 5 || k == 30);
            next_i  = (k == 12 || k == 30);
            @(posedge clk); #1;
        end
        init_i = 1'b0;
        next_i = 1'b0;
        wait_done(n);
        checks++;
        if (n !== 25 || digest_o !== ABC_DIG) begin
            errors++;
            $display("FAIL ignore_round: got rem=%0d digest=%h, want 25 %h", n, digest_o, ABC_DIG);
        end
    endtask

    task automatic test_reset_midround();
        int n;
        issue(1'b1, 1'b0, ABC_BLK);
        repeat (30) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || digest_valid_o !== 1'b0 || digest_o !== 256'h0) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b valid=%b digest=%h, want 1 0 0",
                     ready_o, digest_valid_o, digest_o);
        end
        issue(1'b1, 1'b0, ABC_BLK);
        wait_done(n);
        checks++;
        if (n !== 65 || digest_o !== ABC_DIG) begin
            errors++;
            $display("FAIL reset_mid_abc: got lat=%0d digest=%h, want 65 %h", n, digest_o, ABC_DIG);
        end
    endtask

    task automatic test_next_from_zero();
        int n;
        logic [511:0] b;
        b = rand_block();
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        issue(1'b0, 1'b1, b);
        wait_done(n);
        checks++;
        if (digest_o !== ref_compress(256'h0, b)) begin
            errors++;
            $display("FAIL next_zero: got %h, want %h", digest_o, ref_compress(256'h0, b));
        end
    endtask

    task automatic test_random_chain();
        int n;
        logic [511:0] b;
        logic [255:0] exp_h;
        exp_h = IV_VEC;
        for (int i = 0; i < 4; i++) begin
            b = rand_block();
            issue(i == 0, i != 0, b);
            exp_h = ref_compress(exp_h, b);
            wait_done(n);
            checks++;
            if (n !== 65 || digest_o !== exp_h) begin
                errors++;
                $display("FAIL random_chain[%0d]: got lat=%0d digest=%h, want 65 %h",
                         i, n, digest_o, exp_h);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        init_i  = 1'b1;
        block_i = ABC_BLK;
        @(posedge clk); #1;         // accept edge N, init stays high
        wait_done(n);
        checks++;
        if (n !== 65 || digest_o !== ABC_DIG) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d digest=%h, want 65 %h", n, digest_o, ABC_DIG);
        end
        block_i = EMPTY_BLK;
        @(posedge clk); #1;         // edge N+66 accepts the held init
        init_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || digest_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got ready=%b valid=%b, want 0 0", ready_o, digest_valid_o);
        end
        wait_done(n);
        checks++;
        if (n !== 65 || digest_o !== EMPTY_DIG) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d digest=%h, want 65 %h", n, digest_o, EMPTY_DIG);
        end
    endtask

    initial begin
        rst_i = 1'b1; init_i = 1'b0; next_i = 1'b0; block_i = '0;
        test_reset();
        test_abc();
        test_empty();
        test_two_block();
        test_both_high();
        test_ignore_during_round();
        test_reset_midround();
        test_next_from_zero();
        test_random_chain();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_core.md
SHA256_CORE -- requirements
Module: sha256_core

Interface
REQ-001 The block SHALL have no parameters; the round count is fixed at 64 and the block size is fixed at 512 bits.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 init_i  input  1  start a new hash from the SHA-256 initial values using block_i.
REQ-005 next_i  input  1  continue the current hash, chaining from the present digest, using block_i.
REQ-006 block_i  input  512  message block; word W0 = block_i[511:480], W15 = block_i[31:0].
REQ-007 ready_o  output  1  core idle and able to accept init_i or next_i.
REQ-008 digest_o  output  256  chaining value; H0 = digest_o[255:224], H7 = digest_o[31:0].
REQ-009 digest_valid_o  output  1  digest_o holds the completed result of the last accepted block.

Function
REQ-010 The FSM SHALL have three states: IDLE, ROUND, FINAL.
REQ-011 IDLE: ready_o=1; a command is accepted at the edge where init_i or next_i is high.
REQ-012 If init_i and next_i are both high in IDLE, init_i SHALL take priority.
REQ-013 On accept, the core SHALL capture block_i into a 16-word schedule window and load a..h from the IV on init, or from the current H0..H7 on next.
REQ-014 On init accept, H0..H7 SHALL be loaded with the IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
REQ-015 On accept, ready_o and digest_valid_o SHALL go low and the FSM SHALL move IDLE->ROUND with round counter t=0.
REQ-016 ROUND: one SHA-256 compression round per cycle, t=0..63, using the K[t] constant table and W[t].
REQ-017 W[t] for t>=16 SHALL be computed as sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16] over the sliding window.
REQ-018 All additions SHALL be modulo 2^32 with no carry out.
REQ-019 After round t=63, the FSM SHALL move ROUND->FINAL.
REQ-020 FINAL, one cycle: Hi <= Hi + working variable i for all eight words.
REQ-021 FINAL: the FSM SHALL then move to IDLE with ready_o=1 and digest_valid_o=1.
REQ-022 Latency: a command accepted at edge N SHALL produce ready_o=1 and digest_valid_o=1 after edge N+65.
REQ-023 No new command can be accepted before edge N+66.
REQ-024 init_i and next_i asserted while not in IDLE SHALL be ignored.
REQ-025 Changes on block_i after the accept edge SHALL have no effect on the result.
REQ-026 digest_o SHALL change only at the FINAL edge, on init accept (loaded to the IV), and on reset.
REQ-027 digest_valid_o SHALL stay high in IDLE until the next accept.
REQ-028 next_i issued after reset with no prior init SHALL chain from H=0; this is defined behaviour, not an error.
REQ-029 digest_o SHALL be driven directly from the H registers, with no combinational path from the inputs.

Reset
REQ-030 When rst_i is high at an edge, the core SHALL enter IDLE with ready_o=1, digest_valid_o=0, digest_o=0, t=0, and a..h and the schedule window cleared.
REQ-031 Reset asserted in ROUND or FINAL SHALL abort the block immediately; no partial digest SHALL become visible.
REQ-032 rst_i SHALL take priority over init_i and next_i in the same cycle.

Verification
REQ-033 init with the padded "abc" block (61626380 00000000 ... 00000018) -> digest_valid_o rises 65 edges after accept; digest_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
REQ-034 init with the padded empty message (80000000 0... 0) -> digest_o = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
REQ-035 init with block 1, then next with block 2, of "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> final digest_o = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-036 init and next both high in IDLE with the "abc" block -> result equals REQ-033.
REQ-037 Pulse init_i and next_i during ROUND and toggle block_i during ROUND -> no effect; the "abc" result equals REQ-033.
REQ-038 Assert rst_i at round t=30 -> next cycle ready_o=1, digest_valid_o=0, digest_o=0; a following "abc" init returns the REQ-033 digest.
